// File: rtl/sspis_wb_tmo.sv
// Wishbone request forwarder between the SPI-slave bridge and the interconnect.
// Registers each upstream request and bounds the downstream wait with a timeout.
module sspis_wb_tmo #(
  parameter int unsigned TMO_CYC  = 256,
  parameter logic [31:0] TMO_DATA = 32'hDEAD_0001
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic [31:0] s_adr_i,
  input  logic        s_we_i,
  input  logic [31:0] s_dat_i,
  input  logic [3:0]  s_sel_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        s_err_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic [31:0] m_adr_o,
  output logic        m_we_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        busy_o,
  output logic [7:0]  tmo_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [9:0] WAIT_LAST = 10'(TMO_CYC - 1);

  logic [1:0]  state_q,  state_d;
  logic [9:0]  wait_q,   wait_d;
  logic        m_req_q,  m_req_d;
  logic [31:0] m_adr_q,  m_adr_d;
  logic        m_we_q,   m_we_d;
  logic [31:0] m_dat_q,  m_dat_d;
  logic [3:0]  m_sel_q,  m_sel_d;
  logic [31:0] s_dat_q,  s_dat_d;
  logic        s_ack_q,  s_ack_d;
  logic        s_err_q,  s_err_d;
  logic [7:0]  tmo_q,    tmo_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    m_req_d = m_req_q;
    m_adr_d = m_adr_q;
    m_we_d  = m_we_q;
    m_dat_d = m_dat_q;
    m_sel_d = m_sel_q;
    s_dat_d = s_dat_q;
    s_ack_d = 1'b0;
    s_err_d = 1'b0;
    tmo_d   = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          m_adr_d = s_adr_i;
          m_we_d  = s_we_i;
          m_dat_d = s_dat_i;
          m_sel_d = s_sel_i;
          m_req_d = 1'b1;
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Abort beats everything; a real response beats the expiry on the same cycle.
        if (!s_cyc_i) begin
          m_req_d = 1'b0;
          state_d = ST_IDLE;
        end else if (m_err_i) begin
          m_req_d = 1'b0;
          s_err_d = 1'b1;
          s_dat_d = m_dat_i;
          state_d = ST_RESP;
        end else if (m_ack_i) begin
          m_req_d = 1'b0;
          s_ack_d = 1'b1;
          s_dat_d = m_dat_i;
          state_d = ST_RESP;
        end else if (wait_q == WAIT_LAST) begin
          m_req_d = 1'b0;
          s_err_d = 1'b1;
          s_dat_d = TMO_DATA;
          tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + 10'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      m_req_q <= 1'b0;
      m_adr_q <= '0;
      m_we_q  <= 1'b0;
      m_dat_q <= '0;
      m_sel_q <= '0;
      s_dat_q <= '0;
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      m_req_q <= m_req_d;
      m_adr_q <= m_adr_d;
      m_we_q  <= m_we_d;
      m_dat_q <= m_dat_d;
      m_sel_q <= m_sel_d;
      s_dat_q <= s_dat_d;
      s_ack_q <= s_ack_d;
      s_err_q <= s_err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign m_cyc_o   = m_req_q;
  assign m_stb_o   = m_req_q;
  assign m_adr_o   = m_adr_q;
  assign m_we_o    = m_we_q;
  assign m_dat_o   = m_dat_q;
  assign m_sel_o   = m_sel_q;
  assign s_dat_o   = s_dat_q;
  assign s_ack_o   = s_ack_q;
  assign s_err_o   = s_err_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign tmo_cnt_o = tmo_q;

endmodule

// File: tb/tb_sspis_wb_tmo.sv
// Directed plus randomized checks of sspis_wb_tmo against a transaction-level model
// of expected response kind, data, latency and timeout count.
module tb_sspis_wb_tmo;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] TDATA = 32'hDEAD_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [31:0] s_adr_i, s_dat_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_dat_o;
  logic        s_ack_o, s_err_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i, m_err_i;
  logic        busy_o;
  logic [7:0]  tmo_cnt_o;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  int unsigned model_tmo = 0;
  logic [31:0] model_sdat = '0;

  always #5 clk = ~clk;

  sspis_wb_tmo #(.TMO_CYC(TMO), .TMO_DATA(TDATA)) dut (
    .sys_clk(clk), .rst(rst),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_adr_i(s_adr_i), .s_we_i(s_we_i),
    .s_dat_i(s_dat_i), .s_sel_i(s_sel_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
    .s_err_o(s_err_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_adr_o(m_adr_o),
    .m_we_o(m_we_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .busy_o(busy_o), .tmo_cnt_o(tmo_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cyc"},  {31'd0, m_cyc_o}, 32'd0);
    chk({tag, "_stb"},  {31'd0, m_stb_o}, 32'd0);
    chk({tag, "_we"},   {31'd0, m_we_o},  32'd0);
    chk({tag, "_adr"},  m_adr_o, 32'd0);
    chk({tag, "_mdat"}, m_dat_o, 32'd0);
    chk({tag, "_sel"},  {28'd0, m_sel_o}, 32'd0);
    chk({tag, "_ack"},  {31'd0, s_ack_o}, 32'd0);
    chk({tag, "_err"},  {31'd0, s_err_o}, 32'd0);
    chk({tag, "_sdat"}, s_dat_o, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_tmo"},  {24'd0, tmo_cnt_o}, 32'd0);
  endtask

  // kind: 0 no response, 1 ack, 2 err, 3 ack+err; d = REQ cycles before the response.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int kind, input int d,
                        input logic [31:0] rdata);
    bit          timeout;
    int          n;
    logic        exp_ack, exp_err;
    logic [31:0] exp_dat;
    timeout = (kind == 0) || (d > int'(TMO) - 1);
    n       = timeout ? int'(TMO) : d + 1;
    exp_ack = !timeout && (kind == 1);
    exp_err = timeout || (kind >= 2);
    exp_dat = timeout ? TDATA : rdata;

    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
    s_adr_i = adr; s_dat_i = dat; s_sel_i = sel;
    tick();
    s_stb_i = 1'b0; s_adr_i = $urandom; s_dat_i = $urandom; s_sel_i = 4'($urandom);
    chk("fwd_stb",  {31'd0, m_stb_o}, 32'd1);
    chk("fwd_cyc",  {31'd0, m_cyc_o}, 32'd1);
    chk("fwd_adr",  m_adr_o, adr);
    chk("fwd_dat",  m_dat_o, dat);
    chk("fwd_sel",  {28'd0, m_sel_o}, {28'd0, sel});
    chk("fwd_we",   {31'd0, m_we_o}, {31'd0, we});
    chk("fwd_busy", {31'd0, busy_o}, 32'd1);

    for (int i = 0; i < n; i++) begin
      if (!timeout && i == d) begin
        m_ack_i = (kind == 1) || (kind == 3);
        m_err_i = (kind >= 2);
        m_dat_i = rdata;
      end else begin
        m_dat_i = $urandom;
      end
      tick();
      m_ack_i = 1'b0; m_err_i = 1'b0;
      if (i < n - 1) begin
        chk("wait_stb",  {31'd0, m_stb_o}, 32'd1);
        chk("wait_resp", {30'd0, s_ack_o, s_err_o}, 32'd0);
      end else begin
        if (timeout && model_tmo < 255) model_tmo++;
        model_sdat = exp_dat;
        chk("resp_stb",  {31'd0, m_stb_o}, 32'd0);
        chk("resp_ack",  {31'd0, s_ack_o}, {31'd0, exp_ack});
        chk("resp_err",  {31'd0, s_err_o}, {31'd0, exp_err});
        chk("resp_dat",  s_dat_o, exp_dat);
        chk("resp_tmo",  {24'd0, tmo_cnt_o}, model_tmo);
        chk("resp_busy", {31'd0, busy_o}, 32'd1);
      end
    end

    s_cyc_i = 1'b0;
    m_ack_i = 1'($urandom);
    tick();
    m_ack_i = 1'b0;
    chk("post_pulse", {30'd0, s_ack_o, s_err_o}, 32'd0);
    chk("post_busy",  {31'd0, busy_o}, 32'd0);
    chk("post_hold",  s_dat_o, model_sdat);
  endtask

  initial begin
    rst = 1'b1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    s_adr_i = '0; s_dat_i = '0; s_sel_i = '0;
    m_dat_i = '0; m_ack_i = 1'b0; m_err_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reset_values("rst");

    // Directed read and write
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 2, 32'h1234_5678);
    do_txn(1'b1, 32'h3000_0004, 32'hA5A5_A5A5, 4'b0011, 1, 1, 32'h0BAD_F00D);
    // Timeout, error, ack+err priority, ack on expiry cycle
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 0, 32'h0);
    do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 0, 32'h5555_AAAA);
    do_txn(1'b0, 32'h3000_0028, 32'h0, 4'hF, 3, 1, 32'hCAFE_0003);
    do_txn(1'b0, 32'h3000_002C, 32'h0, 4'hF, 1, int'(TMO) - 1, 32'h7777_0001);

    // Ignored responses while idle
    m_ack_i = 1'b1; m_err_i = 1'b1; m_dat_i = 32'hFFFF_FFFF;
    tick();
    m_ack_i = 1'b0; m_err_i = 1'b0;
    chk("idle_ign_pulse", {30'd0, s_ack_o, s_err_o}, 32'd0);
    chk("idle_ign_dat",   s_dat_o, model_sdat);

    // Abort while waiting
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_adr_i = 32'h3000_0030; s_we_i = 1'b0;
    tick();
    s_stb_i = 1'b0;
    tick();
    s_cyc_i = 1'b0;
    tick();
    chk("abort_cyc",   {31'd0, m_cyc_o}, 32'd0);
    chk("abort_pulse", {30'd0, s_ack_o, s_err_o}, 32'd0);
    chk("abort_busy",  {31'd0, busy_o}, 32'd0);
    chk("abort_tmo",   {24'd0, tmo_cnt_o}, model_tmo);
    tick();
    chk("abort_quiet", {30'd0, s_ack_o, s_err_o}, 32'd0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, TMO + 1)), $urandom);
    end

    // Reset mid-request
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
    s_adr_i = 32'h3000_0040; s_dat_i = 32'h1111_2222; s_sel_i = 4'hF;
    tick();
    s_stb_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; s_cyc_i = 1'b0;
    chk_reset_values("midrst");
    model_tmo = 0;
    model_sdat = '0;
    tick();
    chk("midrst_quiet", {30'd0, s_ack_o, s_err_o}, 32'd0);

    // Saturation of the timeout counter
    for (int t = 0; t < 260; t++) begin
      do_txn(1'b0, $urandom, 32'h0, 4'hF, 0, 0, 32'h0);
    end
    chk("sat_tmo", {24'd0, tmo_cnt_o}, 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sspis_wb_tmo.md
SSPIS_WB_TMO -- requirements
Module: sspis_wb_tmo

Interface
REQ-001 Parameter: TMO_CYC, default 256, number of sys_clk cycles a downstream request may remain unanswered (range 2..1023).
REQ-002 Parameter: TMO_DATA, default 32'hDEAD_0001, read data returned on timeout.
REQ-003 sys_clk  in  1  single block clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 s_cyc_i  in  1  upstream cycle, driven by the SPI-slave bridge wbm_cyc_o.
REQ-006 s_stb_i  in  1  upstream strobe.
REQ-007 s_adr_i  in  32  upstream address.
REQ-008 s_we_i  in  1  upstream write enable.
REQ-009 s_dat_i  in  32  upstream write data.
REQ-010 s_sel_i  in  4  upstream byte enables.
REQ-011 s_dat_o  out  32  read data to upstream.
REQ-012 s_ack_o  out  1  upstream acknowledge, one-cycle pulse.
REQ-013 s_err_o  out  1  upstream error, one-cycle pulse.
REQ-014 m_cyc_o, m_stb_o  out  1 each  downstream cycle/strobe to the interconnect.
REQ-015 m_adr_o  out  32; m_we_o  out  1; m_dat_o  out  32; m_sel_o  out  4  registered copies of the upstream request.
REQ-016 m_dat_i  in  32; m_ack_i  in  1; m_err_i  in  1  downstream response.
REQ-017 busy_o  out  1  high in any state other than IDLE.
REQ-018 tmo_cnt_o  out  8  saturating count of timeouts since reset.

Function
REQ-019 FSM states SHALL be IDLE, REQ, RESP.
REQ-020 IDLE: when s_cyc_i & s_stb_i, SHALL latch adr/we/dat/sel into m_* registers, assert m_cyc_o/m_stb_o on the next edge, clear the wait counter, go to REQ.
REQ-021 Upstream request sampled at edge T SHALL present m_stb_o=1 from T+1 (one-cycle forward latency).
REQ-022 REQ: wait counter SHALL increment by 1 each cycle m_ack_i=0 and m_err_i=0.
REQ-023 REQ with m_ack_i=1: SHALL capture m_dat_i into s_dat_o, drop m_cyc_o/m_stb_o, go to RESP with s_ack_o=1 on the next edge.
REQ-024 REQ with m_err_i=1: SHALL drop m_cyc_o/m_stb_o, go to RESP with s_err_o=1; s_dat_o=m_dat_i captured.
REQ-025 m_ack_i and m_err_i in the same cycle: error SHALL win.
REQ-026 Counter reaching TMO_CYC-1 with no ack/err: SHALL drop m_cyc_o/m_stb_o, load s_dat_o=TMO_DATA, go to RESP with s_err_o=1, increment tmo_cnt_o (saturate at 255).
REQ-027 Ack/err arriving in the same cycle as timeout expiry: ack/err SHALL win; no timeout counted.
REQ-028 RESP: lasts exactly one cycle; s_ack_o/s_err_o SHALL clear on the next edge and FSM returns to IDLE.
REQ-029 s_cyc_i dropping while in REQ (abort): SHALL drop m_cyc_o/m_stb_o next edge, return to IDLE, no s_ack_o/s_err_o pulse, tmo_cnt_o unchanged.
REQ-030 m_ack_i/m_err_i while in IDLE or RESP SHALL be ignored.
REQ-031 s_ack_o and s_err_o SHALL never be high in the same cycle.
REQ-032 s_dat_o SHALL hold its last value until the next response is captured.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE, m_cyc_o=m_stb_o=m_we_o=0, m_adr_o=m_dat_o=0, m_sel_o=0, s_ack_o=s_err_o=0, s_dat_o=0, busy_o=0, tmo_cnt_o=0, wait counter=0.
REQ-034 rst asserted mid-REQ SHALL abandon the transaction on that edge with no upstream response.

Verification
REQ-035 Read: s_* read adr=32'h3000_0010 at T, m_ack_i=1 with m_dat_i=32'h1234_5678 at T+3 -> m_stb_o high T+1..T+3, s_ack_o=1 and s_dat_o=32'h1234_5678 at T+4 only.
REQ-036 Write: adr=32'h3000_0004, dat=32'hA5A5_A5A5, sel=4'b0011 -> identical values on m_* from T+1, m_we_o=1, single s_ack_o pulse after m_ack_i.
REQ-037 Timeout: TMO_CYC=4, no downstream response -> m_stb_o drops after 4 REQ cycles, s_err_o=1 with s_dat_o=32'hDEAD_0001, tmo_cnt_o=1.
REQ-038 Priority: m_ack_i=1 and m_err_i=1 together -> s_err_o=1, s_ack_o=0; ack on the expiry cycle -> s_ack_o=1, tmo_cnt_o unchanged.
REQ-039 Abort/reset: s_cyc_i dropped in REQ -> m_cyc_o=0 next edge, no response; rst=1 mid-REQ -> all outputs at REQ-033 values next edge.
REQ-040 Saturation: 260 consecutive timeouts -> tmo_cnt_o=255.
